// File: rtl/digit_mux.sv
`default_nettype none
// ============================================================================
//  Module   : digit_mux
//  Purpose  : Time-multiplexes NUM_DIGITS hex nibbles onto one shared
//             seven-segment decoder, with per-slot anode blanking and a
//             once-per-frame snapshot of the digit inputs.
//  Revision : 1.0  initial release
// ============================================================================
module digit_mux #(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = 24000,
  parameter int BLANK_CYCLES = 480
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  output logic [3:0]              s,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int c_cnt_w = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam int c_idx_w = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(DWELL_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_blank = c_cnt_w'(BLANK_CYCLES);
  localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(NUM_DIGITS - 1);

  logic [c_cnt_w-1:0]         r_cnt;
  logic [c_idx_w-1:0]         r_idx;
  logic [NUM_DIGITS-1:0][3:0] r_snap;

  logic w_slot_end;
  logic w_frame_first;

  assign w_slot_end    = (r_cnt == c_cnt_last);
  assign w_frame_first = (r_cnt == '0) && (r_idx == '0);

  // Snapshot is taken while the first slot is still blanked, so s only
  // ever changes under all-anodes-off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_snap <= '0;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_frame_first) begin
        r_snap <= digits;
      end
    end
  end

  always_comb begin
    an_n = '1;
    if (r_cnt >= c_cnt_blank) begin
      an_n[r_idx] = 1'b0;
    end
  end

  assign s = r_snap[r_idx];

  // Gated by reset so the pulse drops in the same cycle reset is asserted.
  assign frame_start = w_frame_first && !reset;

endmodule
`default_nettype wire
